image_loader: RTL and testbench
===============================

# image_loader

Upstream feeder for the MNIST inference top. It accepts a raw 8-bit pixel stream over a valid/ready handshake, frames it into 784-pixel images and stores each image in an internal buffer. The buffer is read by the network through a synchronous address/data port that replaces the static image ROM. When an image is complete, the block issues a one-cycle start pulse and holds that buffer stable until the network reports done.

## Interface
Parameters:
- NUM_PIXELS, 784, pixels per image
- PIX_W, 8, input pixel width
- DATA_WIDTH, 16, width of the read-port word
- ADDR_WIDTH, 10, read address width; 2^ADDR_WIDTH ≥ NUM_PIXELS
- FRAC_SHIFT, 0, left shift applied to pixels on write; PIX_W+FRAC_SHIFT ≤ DATA_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  pixel beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  PIX_W  pixel value, unsigned
- s_last  in  1  marks the final pixel of an image
- rd_addr  in  ADDR_WIDTH  network read address
- rd_data  out  DATA_WIDTH  registered pixel of the active buffer
- net_start  out  1  one-cycle pulse: active buffer loaded, start inference
- net_done  in  1  one-cycle pulse: network finished with the active buffer
- err_frame  out  1  one-cycle pulse on a framing error
- frame_count  out  16  images handed to the network, wraps at 0xFFFF→0

## Operation
- Bank states: EMPTY, FILLING, FULL, BUSY. Exactly one bank is BUSY (active) at a time, or none.
- Write side:
  - A beat transfers when s_valid && s_ready.
  - The pixel is stored as zero-extended s_data << FRAC_SHIFT at the write bank's write counter wr_cnt, then wr_cnt increments.
  - The write bank is the lowest-index bank that is EMPTY or FILLING.
  - s_ready = 1 when such a bank exists or the write FSM is in DROP.
- Frame completion: a beat with wr_cnt = NUM_PIXELS−1 and s_last = 1 moves the bank to FULL and clears wr_cnt.
- Early last: s_last = 1 with wr_cnt < NUM_PIXELS−1 pulses err_frame. The bank returns to EMPTY and wr_cnt clears.
- Missing last: the beat at wr_cnt = NUM_PIXELS−1 arrives with s_last = 0.
  - err_frame pulses and the bank returns to EMPTY.
  - The write FSM enters DROP: beats are accepted and discarded up to and including the next s_last, then the FSM returns to WRITE.
- Dispatch: when no bank is BUSY and a bank is FULL, that bank becomes BUSY, net_start pulses and frame_count increments. If two banks are FULL, the older one is dispatched first.
- Release: net_done while a bank is BUSY sets that bank to EMPTY. net_done while no bank is BUSY is ignored.
- Read side: rd_data ← active_bank[rd_addr] every cycle. rd_addr ≥ NUM_PIXELS, or no BUSY bank, returns 0.

## Timing
- Reset values: s_ready 0 during reset and 1 from the first clock after release; rd_data 0; net_start 0; err_frame 0; frame_count 0; all banks EMPTY; write FSM in WRITE.
- Read latency: 1 cycle, rd_addr at edge N gives rd_data valid after edge N+1, matching the prior ROM timing.
- net_start is asserted the cycle after the completing beat when the network is idle. Otherwise it is asserted the cycle after the releasing net_done.
- Same-cycle completion and net_done: the released bank goes EMPTY and the completed bank goes FULL in that cycle. The completed bank is dispatched on the next cycle.
- err_frame is asserted the cycle after the offending beat.
- Write data and the dispatch decision are registered. There is no combinational path from s_valid to s_ready.
- Reset mid-image or mid-inference: all buffered data is discarded and no net_start is issued until a new full frame arrives.

## Configuration
- IMAGE_LOADER_PINGPONG_EN defined: two banks. The next image streams in while the network reads the active one.
- Not defined: one bank. s_ready = 0 while that bank is FULL or BUSY, so the stream stalls until net_done. All other behaviour is unchanged.

## Test plan
- Single frame, pixels i mod 256, s_last on beat 783 -> net_start 1 cycle after beat 783; rd_addr 5 gives rd_data 0x0005 one cycle later; frame_count = 1.
- Early last on beat 99 -> err_frame pulse, no net_start; the next clean frame dispatches normally and rd_addr 99 returns that frame's value.
- Missing last on beat 783, then 10 extra beats with s_last on the 10th -> err_frame pulse, beats dropped with s_ready held 1, no net_start.
- PINGPONG_EN, two back-to-back frames with net_done withheld -> the second frame is FULL with no net_start; net_done -> net_start next cycle, rd_data shows frame 2.
- Without the macro, a second frame during inference -> s_ready = 0 until the cycle after net_done; data is intact.
- Assert rst_n low mid-frame and mid-inference -> every output returns to its reset value; frame_count = 0.

Source files
------------

// File: rtl/image_loader.sv
// image_loader: frames a valid/ready pixel stream into NUM_PIXELS-pixel images and serves the
// active image through a 1-cycle read port. IMAGE_LOADER_PINGPONG_EN selects two banks, else one.
module image_loader #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_W-1:0]      s_data,
  input  logic                  s_last,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  net_start,
  input  logic                  net_done,
  output logic                  err_frame,
  output logic [15:0]           frame_count
);

`ifdef IMAGE_LOADER_PINGPONG_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   NPIX     = (ADDR_WIDTH + 1)'(NUM_PIXELS);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, BUSY} bank_st_e;
  typedef enum logic {WRITE, DROP} wr_st_e;

  bank_st_e              bank_q [NB];
  bank_st_e              bank_d [NB];
  wr_st_e                wst_q, wst_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [NB-1:0]         old_q, old_d;
  logic                  rdy_en_q;
  logic                  net_start_q, net_start_d;
  logic                  err_q, err_d;
  logic [15:0]           fc_q, fc_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [NB-1:0] empty_v, fill_v, full_v, busy_v, full_nx;
  logic [NB-1:0] wb_oh, we, complete, disp;
  logic          beat, rel;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] bank_rd [NB];

  function automatic logic [NB-1:0] lowest(input logic [NB-1:0] v);
    return v & (~v + NB'(1));
  endfunction

  assign wdata = DATA_WIDTH'(s_data) << FRAC_SHIFT;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [NUM_PIXELS];
    always_ff @(posedge clk) begin
      if (we[b]) mem[wr_cnt_q] <= wdata;
    end
    assign bank_rd[b] = mem[rd_addr];
  end

  always_comb begin
    empty_v = '0;
    fill_v  = '0;
    full_v  = '0;
    busy_v  = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      empty_v[b] = (bank_q[b] == EMPTY);
      fill_v[b]  = (bank_q[b] == FILLING);
      full_v[b]  = (bank_q[b] == FULL);
      busy_v[b]  = (bank_q[b] == BUSY);
    end
    // A partially filled bank keeps the stream even if a lower bank is freed mid-frame.
    wb_oh = (fill_v != '0) ? lowest(fill_v) : lowest(empty_v);
  end

  assign s_ready = rdy_en_q & ((wst_q == DROP) | (wb_oh != '0));
  assign beat    = s_valid & s_ready;
  assign rel     = net_done & (busy_v != '0);

  always_comb begin
    bank_d      = bank_q;
    wst_d       = wst_q;
    wr_cnt_d    = wr_cnt_q;
    we          = '0;
    complete    = '0;
    disp        = '0;
    full_nx     = '0;
    err_d       = 1'b0;
    net_start_d = 1'b0;
    fc_d        = fc_q;
    rd_data_d   = '0;

    if (beat) begin
      if (wst_q == DROP) begin
        if (s_last) wst_d = WRITE;
      end else begin
        we = wb_oh;
        if (wr_cnt_q == LAST_IDX) begin
          wr_cnt_d = '0;
          if (s_last) begin
            complete = wb_oh;
          end else begin
            err_d = 1'b1;
            wst_d = DROP;
          end
        end else if (s_last) begin
          err_d    = 1'b1;
          wr_cnt_d = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
        end
      end
    end

    for (int unsigned b = 0; b < NB; b++) begin
      if (we[b]) begin
        if (complete[b])  bank_d[b] = FULL;
        else if (err_d)   bank_d[b] = EMPTY;
        else              bank_d[b] = FILLING;
      end
      if (rel && busy_v[b]) bank_d[b] = EMPTY;
    end

    // Older FULL banks go first; a bank completing this cycle bypasses FULL only when idle.
    if (((busy_v == '0) || rel) && (full_v != '0)) begin
      disp = ((full_v & old_q) != '0) ? old_q : lowest(full_v);
    end else if (busy_v == '0) begin
      disp = complete;
    end

    for (int unsigned b = 0; b < NB; b++) begin
      if (disp[b]) bank_d[b] = BUSY;
      full_nx[b] = (bank_d[b] == FULL);
    end
    if (disp != '0) begin
      net_start_d = 1'b1;
      fc_d        = fc_q + 16'd1;
    end
    old_d = ((old_q & full_nx) != '0) ? old_q : lowest(full_nx);

    for (int unsigned b = 0; b < NB; b++) begin
      if (busy_v[b] && ({1'b0, rd_addr} < NPIX)) rd_data_d = bank_rd[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NB; b++) bank_q[b] <= EMPTY;
      wst_q       <= WRITE;
      wr_cnt_q    <= '0;
      old_q       <= '0;
      rdy_en_q    <= 1'b0;
      net_start_q <= 1'b0;
      err_q       <= 1'b0;
      fc_q        <= '0;
      rd_data_q   <= '0;
    end else begin
      bank_q      <= bank_d;
      wst_q       <= wst_d;
      wr_cnt_q    <= wr_cnt_d;
      old_q       <= old_d;
      rdy_en_q    <= 1'b1;
      net_start_q <= net_start_d;
      err_q       <= err_d;
      fc_q        <= fc_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign net_start   = net_start_q;
  assign err_frame   = err_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader; read results are checked through an expected-value queue.
module tb_image_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic        net_start;
  logic        net_done;
  logic        err_frame;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_err   = 0;
  logic [15:0] exp_q [$];

  image_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .rd_addr(rd_addr), .rd_data(rd_data), .net_start(net_start),
    .net_done(net_done), .err_frame(err_frame), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (net_start) n_start++;
    if (err_frame) n_err++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int unsigned n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int unsigned n, input int unsigned last_at, input int unsigned base);
    for (int unsigned i = 0; i < n; i++) beat(8'((i + base) % 256), i == last_at);
  endtask

  task automatic rd_check(input string tag, input logic [9:0] a, input logic [15:0] e);
    logic [15:0] exp_v;
    rd_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    chk(tag, 32'(rd_data), 32'(exp_v));
  endtask

  task automatic pulse_done();
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rd_addr = '0; net_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_start", 32'(net_start), 32'd0);
    chk("rst_err", 32'(err_frame), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_ready), 32'd1);

    // single clean frame
    send_frame(784, 783, 0);
    chk("t1_start", 32'(net_start), 32'd1);
    chk("t1_count", 32'(frame_count), 32'd1);
    rd_check("t1_rd5", 10'd5, 16'h0005);
    chk("t1_start_pulse", 32'(net_start), 32'd0);
    rd_check("t1_rd783", 10'd783, 16'h000F);
    rd_check("t1_rd_oob", 10'd800, 16'h0000);

`ifdef IMAGE_LOADER_PINGPONG_EN
    chk("pp_ready_busy", 32'(s_ready), 32'd1);
    send_frame(784, 783, 100);
    chk("pp_no_start", 32'(net_start), 32'd0);
    rd_check("pp_rd_old", 10'd5, 16'h0005);
    pulse_done();
    chk("pp_start_after_done", 32'(net_start), 32'd1);
    rd_check("pp_rd_new", 10'd5, 16'd105);
`else
    chk("sb_ready_busy", 32'(s_ready), 32'd0);
    s_valid = 1'b1; s_data = 8'd100; s_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("sb_ready_stall", 32'(s_ready), 32'd0);
      rd_check("sb_rd_hold", 10'(5 + k), 16'(5 + k));
    end
    pulse_done();
    chk("sb_ready_after_done", 32'(s_ready), 32'd1);
    send_frame(784, 783, 100);
    chk("sb_start", 32'(net_start), 32'd1);
    rd_check("sb_rd_new", 10'd99, 16'd199);
`endif
    chk("count2", 32'(frame_count), 32'd2);
    pulse_done();
    rd_check("idle_rd", 10'd5, 16'h0000);
    chk("starts2", 32'(n_start), 32'd2);

    // early last on beat 99
    send_frame(100, 99, 0);
    chk("early_err", 32'(err_frame), 32'd1);
    @(negedge clk);
    chk("early_err_pulse", 32'(err_frame), 32'd0);
    chk("early_no_start", 32'(n_start), 32'd2);
    send_frame(784, 783, 50);
    chk("early_next_start", 32'(net_start), 32'd1);
    rd_check("early_next_rd99", 10'd99, 16'd149);
    chk("early_starts", 32'(n_start), 32'd3);
    pulse_done();

    // missing last, then 10 dropped beats
    send_frame(784, 9999, 0);
    chk("miss_err", 32'(err_frame), 32'd1);
    send_frame(10, 9, 200);
    repeat (2) @(negedge clk);
    chk("miss_no_start", 32'(n_start), 32'd3);
    chk("miss_err_count", 32'(n_err), 32'd2);
    chk("miss_count", 32'(frame_count), 32'd3);
    send_frame(784, 783, 7);
    chk("post_drop_start", 32'(net_start), 32'd1);
    rd_check("post_drop_rd0", 10'd0, 16'd7);
    rd_check("post_drop_rd783", 10'd783, 16'd22);
    pulse_done();

    // reset mid-frame
    send_frame(300, 9999, 0);
    rst_n = 1'b0;
    #1;
    chk("rstf_ready", 32'(s_ready), 32'd0);
    chk("rstf_count", 32'(frame_count), 32'd0);
    chk("rstf_start", 32'(net_start), 32'd0);
    chk("rstf_err", 32'(err_frame), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(484, 483, 44);
    chk("rstf_tail_err", 32'(err_frame), 32'd1);
    repeat (2) @(negedge clk);
    chk("rstf_no_start", 32'(n_start), 32'd4);

    // reset mid-inference
    send_frame(784, 783, 0);
    chk("rsti_start", 32'(net_start), 32'd1);
    chk("rsti_count_pre", 32'(frame_count), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rsti_count", 32'(frame_count), 32'd0);
    chk("rsti_rd", 32'(rd_data), 32'd0);
    chk("rsti_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_check("rsti_rd_after", 10'd5, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rsti_no_start", 32'(n_start), 32'd5);
    chk("rsti_start_low", 32'(net_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
